sync_level_fifo: RTL and testbench



---
 rtl/sync_level_fifo_if.sv | 32 +++
 rtl/sync_level_fifo.sv | 114 +++++++++++
 tb/tb_sync_level_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sync_level_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_level_fifo_if
// Description : Write/read handshake, flush and status bundle for sync_level_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_level_fifo_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             FLUSH;
    logic [WIDTH-1:0] WDATA;
    logic             WVALID;
    logic             WREADY;
    logic [WIDTH-1:0] RDATA;
    logic             RVALID;
    logic             RREADY;
    logic [AW:0]      LEVEL;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;

    modport slave (
        input  FLUSH, WDATA, WVALID, RREADY,
        output WREADY, RDATA, RVALID, LEVEL, ALMOST_FULL, ALMOST_EMPTY
    );

    modport master (
        output FLUSH, WDATA, WVALID, RREADY,
        input  WREADY, RDATA, RVALID, LEVEL, ALMOST_FULL, ALMOST_EMPTY
    );
endinterface
`default_nettype wire

// File: rtl/sync_level_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_level_fifo
// Description : Single-clock FWFT FIFO with occupancy level, programmable
//               almost-full/almost-empty flags and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_level_fifo #(
    parameter int WIDTH        = 32,
    parameter int AW           = 4,
    parameter int AFULL_LEVEL  = (1 << AW) - 1,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    sync_level_fifo_if.slave bus
);
    localparam int          c_depth  = 1 << AW;
    localparam logic [AW:0] c_full   = (AW+1)'(c_depth);
    localparam logic [AW:0] c_afull  = (AW+1)'(AFULL_LEVEL);
    localparam logic [AW:0] c_aempty = (AW+1)'(AEMPTY_LEVEL);
    localparam logic [AW:0] c_one    = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [c_depth];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [AW:0]      r_level;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;
    logic             r_wready;
    logic             r_afull;
    logic             r_aempty;

    logic [AW:0]      w_level_nxt;
    logic             w_wr;
    logic             w_rd;
    logic             w_load;
    logic             w_arr_empty;
    logic             w_bypass;
    logic             w_mem_we;

    assign w_wr        = bus.WVALID & r_wready;
    assign w_rd        = r_rvalid & bus.RREADY;
    assign w_load      = ~r_rvalid | w_rd;
    // The array holds every counted word except the one in the output register.
    assign w_arr_empty = (r_level == {{AW{1'b0}}, r_rvalid});
    assign w_bypass    = w_load & w_arr_empty & w_wr;
    assign w_mem_we    = w_wr & ~w_bypass & ~RESET & ~bus.FLUSH;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_rd) begin
            w_level_nxt = r_level + c_one;
        end else if (!w_wr && w_rd) begin
            w_level_nxt = r_level - c_one;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[r_wptr[AW-1:0]] <= bus.WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_wready <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else if (bus.FLUSH) begin
            // RDATA is left untouched; it is don't-care while RVALID is low.
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_rvalid <= 1'b0;
            r_wready <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_level  <= w_level_nxt;
            r_wready <= (w_level_nxt < c_full);
            r_afull  <= (w_level_nxt >= c_afull);
            r_aempty <= (w_level_nxt <= c_aempty);
            if (w_wr && !w_bypass) begin
                r_wptr <= r_wptr + c_one;
            end
            if (w_load) begin
                if (!w_arr_empty) begin
                    r_rdata  <= r_mem[r_rptr[AW-1:0]];
                    r_rptr   <= r_rptr + c_one;
                    r_rvalid <= 1'b1;
                end else if (w_wr) begin
                    r_rdata  <= bus.WDATA;
                    r_rvalid <= 1'b1;
                end else begin
                    r_rvalid <= 1'b0;
                end
            end
        end
    end

    assign bus.WREADY       = r_wready;
    assign bus.RDATA        = r_rdata;
    assign bus.RVALID       = r_rvalid;
    assign bus.LEVEL        = r_level;
    assign bus.ALMOST_FULL  = r_afull;
    assign bus.ALMOST_EMPTY = r_aempty;
endmodule
`default_nettype wire

// File: tb/tb_sync_level_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_level_fifo
// Description : Directed-vector bench for sync_level_fifo (WIDTH=8, AW=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_level_fifo;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    sync_level_fifo_if #(.WIDTH(8), .AW(2)) bus ();

    sync_level_fifo #(
        .WIDTH        (8),
        .AW           (2),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level"},  32'(bus.LEVEL), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.RVALID), 32'd0);
        check({tag, "_wready"}, 32'(bus.WREADY), 32'd1);
        check({tag, "_aempty"}, 32'(bus.ALMOST_EMPTY), 32'd1);
        check({tag, "_afull"},  32'(bus.ALMOST_FULL), 32'd0);
    endtask

    task automatic push(input logic [7:0] d);
        bus.WVALID = 1'b1;
        bus.WDATA  = d;
        step();
        bus.WVALID = 1'b0;
    endtask

    logic [7:0] fill_data [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] fill_lvl  [5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       fill_af   [5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       fill_ae   [5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       fill_wr   [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] drain_dat [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] drain_lvl [4]  = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic       drain_ae  [4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       drain_rv  [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        rst        = 1'b1;
        bus.FLUSH  = 1'b0;
        bus.WDATA  = '0;
        bus.WVALID = 1'b0;
        bus.RREADY = 1'b0;
        step();
        rst = 1'b0;
        check_reset_state("reset");
        check("reset_rdata", 32'(bus.RDATA), 32'h0);

        // Fill with the consumer stalled; fifth write must be refused.
        bus.WVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.WDATA = fill_data[i];
            step();
            check($sformatf("fill%0d_level", i), 32'(bus.LEVEL), 32'(fill_lvl[i]));
            check($sformatf("fill%0d_afull", i), 32'(bus.ALMOST_FULL), 32'(fill_af[i]));
            check($sformatf("fill%0d_aempty", i), 32'(bus.ALMOST_EMPTY), 32'(fill_ae[i]));
            check($sformatf("fill%0d_wready", i), 32'(bus.WREADY), 32'(fill_wr[i]));
            check($sformatf("fill%0d_rdata", i), 32'(bus.RDATA), 32'h11);
            check($sformatf("fill%0d_rvalid", i), 32'(bus.RVALID), 32'd1);
        end
        bus.WVALID = 1'b0;

        // Drain in order.
        bus.RREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_rdata", i), 32'(bus.RDATA), 32'(drain_dat[i]));
            step();
            check($sformatf("drain%0d_level", i), 32'(bus.LEVEL), 32'(drain_lvl[i]));
            check($sformatf("drain%0d_aempty", i), 32'(bus.ALMOST_EMPTY), 32'(drain_ae[i]));
            check($sformatf("drain%0d_rvalid", i), 32'(bus.RVALID), 32'(drain_rv[i]));
        end
        bus.RREADY = 1'b0;

        // Full with simultaneous write and read: read wins, write lands next cycle.
        for (int i = 1; i <= 4; i++) push(8'(8'hA0 + i));
        check("full_level", 32'(bus.LEVEL), 32'd4);
        bus.WVALID = 1'b1;
        bus.WDATA  = 8'hA5;
        bus.RREADY = 1'b1;
        step();
        check("simul_level", 32'(bus.LEVEL), 32'd3);
        check("simul_wready", 32'(bus.WREADY), 32'd1);
        check("simul_rdata", 32'(bus.RDATA), 32'hA2);
        step();
        check("simul2_level", 32'(bus.LEVEL), 32'd3);
        check("simul2_rdata", 32'(bus.RDATA), 32'hA3);
        bus.WVALID = 1'b0;
        step();
        check("simul3_rdata", 32'(bus.RDATA), 32'hA4);
        step();
        check("simul4_rdata", 32'(bus.RDATA), 32'hA5);
        step();
        check("simul5_rvalid", 32'(bus.RVALID), 32'd0);
        check("simul5_level", 32'(bus.LEVEL), 32'd0);

        // Streaming from empty through the bypass path.
        bus.RREADY = 1'b1;
        bus.WVALID = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.WDATA = 8'(i);
            step();
            check($sformatf("stream%0d_rdata", i), 32'(bus.RDATA), 32'(i));
            check($sformatf("stream%0d_rvalid", i), 32'(bus.RVALID), 32'd1);
            check($sformatf("stream%0d_level", i), 32'(bus.LEVEL), 32'd1);
        end
        bus.WVALID = 1'b0;
        step();
        check("stream_end_rvalid", 32'(bus.RVALID), 32'd0);
        check("stream_end_level", 32'(bus.LEVEL), 32'd0);
        bus.RREADY = 1'b0;

        // Flush at level 3 with a concurrent write that must be dropped.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("preflush_level", 32'(bus.LEVEL), 32'd3);
        bus.FLUSH  = 1'b1;
        bus.WVALID = 1'b1;
        bus.WDATA  = 8'hAA;
        step();
        bus.FLUSH  = 1'b0;
        bus.WVALID = 1'b0;
        check_reset_state("flush");
        push(8'hBB);
        check("postflush_rdata", 32'(bus.RDATA), 32'hBB);
        check("postflush_rvalid", 32'(bus.RVALID), 32'd1);
        check("postflush_level", 32'(bus.LEVEL), 32'd1);
        bus.RREADY = 1'b1;
        step();
        check("postflush_drained", 32'(bus.LEVEL), 32'd0);
        bus.RREADY = 1'b0;

        // Reset together with flush: reset values, including RDATA.
        push(8'hC1);
        push(8'hC2);
        push(8'hC3);
        rst        = 1'b1;
        bus.FLUSH  = 1'b1;
        bus.WVALID = 1'b1;
        bus.WDATA  = 8'hC4;
        step();
        rst        = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.WVALID = 1'b0;
        check_reset_state("rstflush");
        check("rstflush_rdata", 32'(bus.RDATA), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
